// File: rtl/id_stage_hazard.sv
// Decode stage: register file with write-back bypass, load-use detection, and the ID/EX pipeline register.
// The controller and extend blocks follow the pipeline's standard RV32 decode tables.
module id_stage_hazard #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int ALUCTRL_W = 3,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      PCD,
  input  logic [XLEN-1:0]      PCPlus4D,
  input  logic [31:0]          InstrD,
  input  logic                 ValidD,
  input  logic                 FlushE,
  input  logic                 RegWriteW,
  input  logic [AW-1:0]        RDW,
  input  logic [XLEN-1:0]      ResultW,
  output logic                 StallD,
  output logic                 ValidE,
  output logic [XLEN-1:0]      PCE,
  output logic [XLEN-1:0]      PCPlus4E,
  output logic [XLEN-1:0]      RD1E,
  output logic [XLEN-1:0]      RD2E,
  output logic [XLEN-1:0]      IMMEXIE,
  output logic [AW-1:0]        RDE,
  output logic [AW-1:0]        RS1E,
  output logic [AW-1:0]        RS2E,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic                 JumpE,
  output logic                 BranchE,
  output logic                 AluSrcE,
  output logic [1:0]           ResultSrcE,
  output logic [ALUCTRL_W-1:0] AluControlE
);

  logic [XLEN-1:0] regs [NREGS];
  logic [AW-1:0]   rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0] rd1_d, rd2_d, imm_d;
  logic [31:0]     imm32_d;
  logic            reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
  logic [1:0]      result_src_d, imm_src_d;
  logic [2:0]      alu_control_d;
  logic            load_use, bubble;

  assign rs1_d = InstrD[15 +: AW];
  assign rs2_d = InstrD[20 +: AW];
  assign rd_d  = InstrD[7 +: AW];

  controller u_controller (
    .op          (InstrD[6:0]),
    .funct3      (InstrD[14:12]),
    .funct7b5    (InstrD[30]),
    .reg_write   (reg_write_d),
    .result_src  (result_src_d),
    .mem_write   (mem_write_d),
    .jump        (jump_d),
    .branch      (branch_d),
    .alu_src     (alu_src_d),
    .imm_src     (imm_src_d),
    .alu_control (alu_control_d)
  );

  extend u_extend (
    .instr   (InstrD[31:7]),
    .imm_src (imm_src_d),
    .imm_ext (imm32_d)
  );

  assign imm_d = XLEN'($signed(imm32_d));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (RegWriteW && RDW != '0) begin
      regs[RDW] <= ResultW;
    end
  end

  // Write-back data is forwarded so ID never sees a stale value in the write cycle.
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (rs1_d != '0) rd1_d = (RegWriteW && RDW == rs1_d) ? ResultW : regs[rs1_d];
    if (rs2_d != '0) rd2_d = (RegWriteW && RDW == rs2_d) ? ResultW : regs[rs2_d];
  end

  assign load_use = ValidD && ValidE && (ResultSrcE == 2'b01) && (RDE != '0) &&
                    ((rs1_d == RDE) || (rs2_d == RDE));
  assign StallD   = load_use && !FlushE;
  assign bubble   = FlushE || load_use || !ValidD;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || bubble) begin
      ValidE      <= 1'b0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      IMMEXIE     <= '0;
      RDE         <= '0;
      RS1E        <= '0;
      RS2E        <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      AluSrcE     <= 1'b0;
      ResultSrcE  <= 2'b00;
      AluControlE <= '0;
    end else begin
      ValidE      <= 1'b1;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      RD1E        <= rd1_d;
      RD2E        <= rd2_d;
      IMMEXIE     <= imm_d;
      RDE         <= rd_d;
      RS1E        <= rs1_d;
      RS2E        <= rs2_d;
      RegWriteE   <= reg_write_d;
      MemWriteE   <= mem_write_d;
      JumpE       <= jump_d;
      BranchE     <= branch_d;
      AluSrcE     <= alu_src_d;
      ResultSrcE  <= result_src_d;
      AluControlE <= ALUCTRL_W'(alu_control_d);
    end
  end

endmodule

// Main and ALU decoder; unsupported opcodes fall through to all-zero controls.
module controller (
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic       mem_write,
  output logic       jump,
  output logic       branch,
  output logic       alu_src,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control
);

  logic [1:0] alu_op;

  always_comb begin
    reg_write  = 1'b0;
    result_src = 2'b00;
    mem_write  = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    alu_src    = 1'b0;
    imm_src    = 2'b00;
    alu_op     = 2'b00;
    case (op)
      7'b0000011: begin reg_write = 1'b1; alu_src = 1'b1; result_src = 2'b01; end
      7'b0100011: begin mem_write = 1'b1; alu_src = 1'b1; imm_src = 2'b01; end
      7'b0110011: begin reg_write = 1'b1; alu_op = 2'b10; end
      7'b0010011: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 2'b10; end
      7'b1100011: begin branch = 1'b1; imm_src = 2'b10; alu_op = 2'b01; end
      7'b1101111: begin reg_write = 1'b1; jump = 1'b1; result_src = 2'b10; imm_src = 2'b11; end
      default: ;
    endcase
  end

  // Only R-type uses funct7 bit 5 to select subtract; addi must stay an add.
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (op[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// Immediate generator for I, S, B and J formats.
module extend (
  input  logic [31:7] instr,
  input  logic [1:0]  imm_src,
  output logic [31:0] imm_ext
);

  always_comb begin
    imm_ext = '0;
    case (imm_src)
      2'b00: imm_ext = {{20{instr[31]}}, instr[31:20]};
      2'b01: imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      2'b10: imm_ext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      2'b11: imm_ext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_id_stage_hazard.sv
// Scoreboard bench for id_stage_hazard: directed hazard/bypass cases, a randomised run
// against an ISA-level model, an async reset mid-run, and a 64-bit immediate check.
module tb_id_stage_hazard;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [31:0] ADD_X7_X5_X0 = {7'd0, 5'd0, 5'd5, 3'b000, 5'd7, OP_R};
  localparam logic [31:0] ADD_X9_X0_X0 = {7'd0, 5'd0, 5'd0, 3'b000, 5'd9, OP_R};
  localparam logic [31:0] LW_X6_0_X1   = {12'd0, 5'd1, 3'b010, 5'd6, OP_LW};
  localparam logic [31:0] ADD_X8_X6_X1 = {7'd0, 5'd1, 5'd6, 3'b000, 5'd8, OP_R};
  localparam logic [31:0] ADDI_X1_M1   = 32'hFFF0_0093;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [31:0] PCD, PCPlus4D, InstrD, ResultW;
  logic        ValidD, FlushE, RegWriteW;
  logic [4:0]  RDW;
  logic        StallD, ValidE, RegWriteE, MemWriteE, JumpE, BranchE, AluSrcE;
  logic [31:0] PCE, PCPlus4E, RD1E, RD2E, IMMEXIE;
  logic [4:0]  RDE, RS1E, RS2E;
  logic [1:0]  ResultSrcE;
  logic [2:0]  AluControlE;

  logic [63:0] PCD64, PCPlus4D64, ResultW64;
  logic [31:0] InstrD64;
  logic        ValidD64, FlushE64, RegWriteW64;
  logic [4:0]  RDW64;
  logic        StallD64, ValidE64, RegWriteE64, MemWriteE64, JumpE64, BranchE64, AluSrcE64;
  logic [63:0] PCE64, PCPlus4E64, RD1E64, RD2E64, IMMEXIE64;
  logic [4:0]  RDE64, RS1E64, RS2E64;
  logic [1:0]  ResultSrcE64;
  logic [2:0]  AluControlE64;

  id_stage_hazard dut (
    .clk(clk), .reset(reset), .PCD(PCD), .PCPlus4D(PCPlus4D), .InstrD(InstrD), .ValidD(ValidD),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .StallD(StallD),
    .ValidE(ValidE), .PCE(PCE), .PCPlus4E(PCPlus4E), .RD1E(RD1E), .RD2E(RD2E), .IMMEXIE(IMMEXIE),
    .RDE(RDE), .RS1E(RS1E), .RS2E(RS2E), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .AluSrcE(AluSrcE), .ResultSrcE(ResultSrcE),
    .AluControlE(AluControlE)
  );

  id_stage_hazard #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .PCD(PCD64), .PCPlus4D(PCPlus4D64), .InstrD(InstrD64),
    .ValidD(ValidD64), .FlushE(FlushE64), .RegWriteW(RegWriteW64), .RDW(RDW64),
    .ResultW(ResultW64), .StallD(StallD64), .ValidE(ValidE64), .PCE(PCE64),
    .PCPlus4E(PCPlus4E64), .RD1E(RD1E64), .RD2E(RD2E64), .IMMEXIE(IMMEXIE64), .RDE(RDE64),
    .RS1E(RS1E64), .RS2E(RS2E64), .RegWriteE(RegWriteE64), .MemWriteE(MemWriteE64),
    .JumpE(JumpE64), .BranchE(BranchE64), .AluSrcE(AluSrcE64), .ResultSrcE(ResultSrcE64),
    .AluControlE(AluControlE64)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, pc4, rd1, rd2, imm;
    logic [4:0]  rd, rs1, rs2;
    logic        reg_write, mem_write, jump, branch, alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_ctrl;
  } ex_t;

  ex_t         exp_q[$];
  ex_t         model_e;
  logic [31:0] model_regs [32];
  logic [31:0] pc_ctr;
  int          tests = 0;
  int          fails = 0;

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic ex_t sample_dut();
    ex_t s;
    s.valid = ValidE; s.pc = PCE; s.pc4 = PCPlus4E; s.rd1 = RD1E; s.rd2 = RD2E; s.imm = IMMEXIE;
    s.rd = RDE; s.rs1 = RS1E; s.rs2 = RS2E; s.reg_write = RegWriteE; s.mem_write = MemWriteE;
    s.jump = JumpE; s.branch = BranchE; s.alu_src = AluSrcE; s.result_src = ResultSrcE;
    s.alu_ctrl = AluControlE;
    return s;
  endfunction

  function automatic logic [2:0] alu_fn(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Reference decode by instruction class, as the ISA describes each format.
  function automatic ex_t ref_decode(input logic [31:0] instr, input logic [31:0] pc,
                                     input logic [31:0] pc4, input logic [31:0] r1,
                                     input logic [31:0] r2);
    ex_t e;
    e = '0;
    e.valid = 1'b1; e.pc = pc; e.pc4 = pc4; e.rd1 = r1; e.rd2 = r2;
    e.rd = instr[11:7]; e.rs1 = instr[19:15]; e.rs2 = instr[24:20];
    e.imm = {{20{instr[31]}}, instr[31:20]};
    case (instr[6:0])
      OP_LW:  begin e.reg_write = 1; e.alu_src = 1; e.result_src = 2'b01; end
      OP_SW:  begin e.mem_write = 1; e.alu_src = 1; e.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]}; end
      OP_R:   begin e.reg_write = 1; e.alu_ctrl = alu_fn(instr[14:12], instr[30]); end
      OP_I:   begin e.reg_write = 1; e.alu_src = 1; e.alu_ctrl = alu_fn(instr[14:12], 1'b0); end
      OP_BEQ: begin
        e.branch = 1; e.alu_ctrl = 3'b001;
        e.imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_JAL: begin
        e.reg_write = 1; e.jump = 1; e.result_src = 2'b10;
        e.imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] read_ref(input logic [4:0] idx, input logic rw,
                                           input logic [4:0] rdw, input logic [31:0] res);
    if (idx == 5'd0) return 32'd0;
    if (rw && rdw == idx) return res;
    return model_regs[idx];
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    w[11:7]  = 5'($urandom_range(0, 7));
    case (k)
      0, 1, 2: w[6:0] = OP_LW;
      3:       w[6:0] = OP_SW;
      4, 5:    w[6:0] = OP_R;
      6:       w[6:0] = OP_I;
      7:       w[6:0] = OP_BEQ;
      8:       w[6:0] = OP_JAL;
      default: w[6:0] = 7'b0110111;
    endcase
    return w;
  endfunction

  task automatic apply_stimulus(input logic [31:0] instr, input logic vd, input logic fl,
                                input logic rw, input logic [4:0] rdw, input logic [31:0] res,
                                output logic stall_seen);
    logic lu;
    ex_t  nxt;
    @(negedge clk);
    InstrD = instr; ValidD = vd; FlushE = fl; RegWriteW = rw; RDW = rdw; ResultW = res;
    PCD = pc_ctr; PCPlus4D = pc_ctr + 32'd4;
    #1;
    lu = vd && model_e.valid && model_e.result_src == 2'b01 && model_e.rd != 5'd0 &&
         (instr[19:15] == model_e.rd || instr[24:20] == model_e.rd);
    check_output("stall", 256'(StallD), 256'(lu && !fl));
    if (fl || lu || !vd) nxt = '0;
    else nxt = ref_decode(instr, PCD, PCPlus4D, read_ref(instr[19:15], rw, rdw, res),
                          read_ref(instr[24:20], rw, rdw, res));
    exp_q.push_back(nxt);
    model_e = nxt;
    if (rw && rdw != 5'd0) model_regs[rdw] = res;
    stall_seen = StallD;
    if (!StallD) pc_ctr += 32'd4;
  endtask

  // Monitor: the ID/EX register presents a new value each cycle, checked against the queue head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        ex_t e;
        e = exp_q.pop_front();
        check_output("ex_reg", 256'(sample_dut()), 256'(e));
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        st, vd, fl, rw;
    logic [31:0] instr;
    reset = 1'b0;
    PCD = '0; PCPlus4D = '0; InstrD = '0; ValidD = 0; FlushE = 0; RegWriteW = 0; RDW = '0; ResultW = '0;
    PCD64 = 64'h100; PCPlus4D64 = 64'h104; InstrD64 = '0; ValidD64 = 0; FlushE64 = 0;
    RegWriteW64 = 0; RDW64 = '0; ResultW64 = '0;
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    model_e = '0;
    pc_ctr = 32'h1000;
    st = 0;

    #12;
    check_output("reset_state", 256'(sample_dut()), 256'(0));
    @(negedge clk);
    reset = 1'b1;

    apply_stimulus(ADD_X7_X5_X0, 1, 0, 1, 5'd5, 32'hDEAD_BEEF, st);
    @(posedge clk); #1;
    check_output("bypass_rd1", 256'(RD1E), 256'(32'hDEAD_BEEF));

    apply_stimulus(ADD_X9_X0_X0, 1, 0, 1, 5'd0, 32'h1234, st);
    @(posedge clk); #1;
    check_output("x0_no_bypass", 256'(RD1E), 256'(0));
    apply_stimulus(ADD_X9_X0_X0, 1, 0, 0, 5'd0, 32'h0, st);
    @(posedge clk); #1;
    check_output("x0_read", 256'(RD1E), 256'(0));

    apply_stimulus(LW_X6_0_X1, 1, 0, 0, 5'd0, 32'h0, st);
    apply_stimulus(ADD_X8_X6_X1, 1, 0, 0, 5'd0, 32'h0, st);
    check_output("load_use_stall", 256'(st), 256'(1));
    @(posedge clk); #1;
    check_output("load_use_bubble", 256'({ValidE, RegWriteE, ResultSrcE}), 256'(0));

    apply_stimulus(ADD_X8_X6_X1, 1, 0, 0, 5'd0, 32'h0, st);
    check_output("load_moved_on", 256'(st), 256'(0));
    @(posedge clk); #1;
    check_output("add_enters", 256'(ValidE), 256'(1));

    apply_stimulus(LW_X6_0_X1, 1, 0, 0, 5'd0, 32'h0, st);
    apply_stimulus(ADD_X8_X6_X1, 1, 1, 0, 5'd0, 32'h0, st);
    check_output("flush_hazard_stall", 256'(st), 256'(0));
    @(posedge clk); #1;
    check_output("flush_hazard_bubble", 256'({ValidE, RegWriteE}), 256'(0));

    @(negedge clk);
    InstrD64 = ADDI_X1_M1; ValidD64 = 1;
    @(posedge clk); #1;
    check_output("imm64", 256'(IMMEXIE64), 256'(64'hFFFF_FFFF_FFFF_FFFF));
    check_output("valid64", 256'(ValidE64), 256'(1));
    @(negedge clk);
    ValidD64 = 0;
    @(posedge clk); #1;
    check_output("bubble64", 256'({ValidE64, IMMEXIE64, RegWriteE64}), 256'(0));

    st = 0;
    vd = 1;
    instr = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!st) begin
        instr = rand_instr();
        vd = ($urandom_range(0, 7) != 0);
      end
      fl = ($urandom_range(0, 7) == 0);
      rw = $urandom_range(0, 1) == 1;
      apply_stimulus(instr, vd, fl, rw, 5'($urandom_range(0, 7)), $urandom, st);
    end

    @(posedge clk);
    #2;
    ValidD = 0; FlushE = 0; RegWriteW = 0;
    reset = 1'b0;
    #1;
    check_output("async_reset", 256'(sample_dut()), 256'(0));
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    model_e = '0;
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus(ADD_X7_X5_X0, 1, 0, 0, 5'd0, 32'h0, st);
    @(posedge clk); #1;
    check_output("x5_after_reset", 256'(RD1E), 256'(0));

    repeat (3) @(posedge clk);
    #2;
    check_output("queue_drain", 256'(exp_q.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
